// File: rtl/cpu64_l2_a_arbiter.sv
// -----------------------------------------------------------------------------
// cpu64_l2_a_arbiter
//
// Merges the per-core L1 TileLink A channels (Acquire requests) into the single
// L2 A-channel sink. Valid cores are arbitrated round-robin. The core ID is
// stamped into the upper source bits. The winning request lands in a one-entry
// registered output stage. All A messages here are single-beat, so a grant
// never has to be held across cycles.
//
// Ports
//   clk_i, rst_i        clock; asynchronous active-high reset
//   l1_a_opcode_i       CORES*3 per-core opcode, core k at [3k+2:3k]
//   l1_a_param_i        CORES*3 per-core param, same packing
//   l1_a_source_i       CORES*L1_SOURCE_W per-core source
//   l1_a_address_i      CORES*ADDR_W per-core address
//   l1_a_valid_i        CORES per-core valid
//   l1_a_ready_o        CORES per-core ready (one-hot or zero)
//   tl_a_*_o            registered request to the L2 A sink
//   tl_a_ready_i        L2 A ready
//   last_grant_o        core ID of the most recent grant (debug)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A producer holds valid and its payload stable until that transfer, and
// valid never depends on ready. Ready may depend on valid. Upstream, the
// arbiter raises ready only on the winning core. Downstream, tl_a_valid_o
// reflects the occupied output register.
// -----------------------------------------------------------------------------
module cpu64_l2_a_arbiter #(
    parameter int CORES       = 4,
    parameter int ADDR_W      = 64,
    parameter int L1_SOURCE_W = 4,
    parameter int CID_W       = 2,
    parameter int SOURCE_W    = 6
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [CORES*3-1:0]           l1_a_opcode_i,
    input  logic [CORES*3-1:0]           l1_a_param_i,
    input  logic [CORES*L1_SOURCE_W-1:0] l1_a_source_i,
    input  logic [CORES*ADDR_W-1:0]      l1_a_address_i,
    input  logic [CORES-1:0]             l1_a_valid_i,
    output logic [CORES-1:0]             l1_a_ready_o,
    output logic [2:0]                   tl_a_opcode_o,
    output logic [2:0]                   tl_a_param_o,
    output logic [SOURCE_W-1:0]          tl_a_source_o,
    output logic [ADDR_W-1:0]            tl_a_address_o,
    output logic                         tl_a_valid_o,
    input  logic                         tl_a_ready_i,
    output logic [CID_W-1:0]             last_grant_o
);

    // Output register and arbitration state
    logic                valid_q;
    logic [2:0]          opcode_q;
    logic [2:0]          param_q;
    logic [SOURCE_W-1:0] source_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [CID_W-1:0]    rr_q;
    logic [CID_W-1:0]    last_grant_q;

    logic             load_en;
    logic             any_valid;
    logic [CID_W-1:0] win;
    logic             grant;
    logic [CID_W-1:0] idx;

    // The slot is free, or it drains on this edge.
    assign load_en = !valid_q || tl_a_ready_i;

    // Scan from rr_q upward. CORES is a power of two, so the CID_W-bit sum wraps
    // the index modulo CORES without extra logic.
    always_comb begin
        any_valid = 1'b0;
        win       = '0;
        idx       = '0;
        for (int i = 0; i < CORES; i++) begin
            idx = rr_q + CID_W'(i);
            if (!any_valid && l1_a_valid_i[idx]) begin
                any_valid = 1'b1;
                win       = idx;
            end
        end
    end

    assign grant = load_en && any_valid && !rst_i;

    always_comb begin
        l1_a_ready_o = '0;
        if (grant) begin
            l1_a_ready_o[win] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q      <= 1'b0;
            opcode_q     <= '0;
            param_q      <= '0;
            source_q     <= '0;
            addr_q       <= '0;
            rr_q         <= '0;
            last_grant_q <= '0;
        end else if (grant) begin
            // Covers both a plain load and drain+load in the same cycle.
            valid_q      <= 1'b1;
            opcode_q     <= l1_a_opcode_i[int'(win)*3 +: 3];
            param_q      <= l1_a_param_i[int'(win)*3 +: 3];
            source_q     <= {win, l1_a_source_i[int'(win)*L1_SOURCE_W +: L1_SOURCE_W]};
            addr_q       <= l1_a_address_i[int'(win)*ADDR_W +: ADDR_W];
            rr_q         <= win + CID_W'(1);
            last_grant_q <= win;
        end else if (valid_q && tl_a_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign tl_a_valid_o   = valid_q;
    assign tl_a_opcode_o  = opcode_q;
    assign tl_a_param_o   = param_q;
    assign tl_a_source_o  = source_q;
    assign tl_a_address_o = addr_q;
    assign last_grant_o   = last_grant_q;

endmodule

// File: tb/tb_cpu64_l2_a_arbiter.sv
module tb_cpu64_l2_a_arbiter;

    localparam int CORES = 4;
    localparam int ADDR_W = 64;
    localparam int L1_SOURCE_W = 4;
    localparam int CID_W = 2;
    localparam int SOURCE_W = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [CORES*3-1:0]           l1_a_opcode;
    logic [CORES*3-1:0]           l1_a_param;
    logic [CORES*L1_SOURCE_W-1:0] l1_a_source;
    logic [CORES*ADDR_W-1:0]      l1_a_address;
    logic [CORES-1:0]             l1_a_valid;
    logic [CORES-1:0]             l1_a_ready;
    logic [2:0]                   tl_a_opcode;
    logic [2:0]                   tl_a_param;
    logic [SOURCE_W-1:0]          tl_a_source;
    logic [ADDR_W-1:0]            tl_a_address;
    logic                         tl_a_valid;
    logic                         tl_a_ready;
    logic [CID_W-1:0]             last_grant;

    int n_vec = 0;
    int n_err = 0;

    cpu64_l2_a_arbiter #(
        .CORES(CORES), .ADDR_W(ADDR_W), .L1_SOURCE_W(L1_SOURCE_W),
        .CID_W(CID_W), .SOURCE_W(SOURCE_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .l1_a_opcode_i(l1_a_opcode),
        .l1_a_param_i(l1_a_param),
        .l1_a_source_i(l1_a_source),
        .l1_a_address_i(l1_a_address),
        .l1_a_valid_i(l1_a_valid),
        .l1_a_ready_o(l1_a_ready),
        .tl_a_opcode_o(tl_a_opcode),
        .tl_a_param_o(tl_a_param),
        .tl_a_source_o(tl_a_source),
        .tl_a_address_o(tl_a_address),
        .tl_a_valid_o(tl_a_valid),
        .tl_a_ready_i(tl_a_ready),
        .last_grant_o(last_grant)
    );

    // ---------------- driver tasks ----------------
    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int k, input logic v, input logic [2:0] op,
                            input logic [2:0] prm, input logic [3:0] src,
                            input logic [63:0] addr);
        l1_a_valid[k]              = v;
        l1_a_opcode[k*3 +: 3]      = op;
        l1_a_param[k*3 +: 3]       = prm;
        l1_a_source[k*4 +: 4]      = src;
        l1_a_address[k*64 +: 64]   = addr;
        #0;
    endtask

    task automatic clear_all();
        l1_a_valid   = '0;
        l1_a_opcode  = '0;
        l1_a_param   = '0;
        l1_a_source  = '0;
        l1_a_address = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_all();
        tl_a_ready = 1'b1;
        rst = 1'b1;
        set_core(0, 1'b1, 3'd4, 3'd0, 4'h1, 64'h40);
        step();
        #1;
        n_vec++;
        if (l1_a_ready !== 4'b0000) begin
            n_err++; $display("FAIL reset_ready got %b want 0000", l1_a_ready);
        end
        n_vec++;
        if ({tl_a_valid, tl_a_opcode, tl_a_param, tl_a_source, tl_a_address, last_grant} !== '0) begin
            n_err++; $display("FAIL reset_outputs valid=%b op=%h src=%h addr=%h lg=%0d want all 0",
                              tl_a_valid, tl_a_opcode, tl_a_source, tl_a_address, last_grant);
        end
        clear_all();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        tl_a_ready = 1'b1;
        set_core(2, 1'b1, 3'd6, 3'd1, 4'h5, 64'h1000);
        #1;
        n_vec++;
        if (l1_a_ready !== 4'b0100) begin
            n_err++; $display("FAIL single_ready got %b want 0100", l1_a_ready);
        end
        step();
        clear_all();
        #1;
        n_vec++;
        if (tl_a_valid !== 1'b1 || tl_a_source !== 6'h25 || tl_a_address !== 64'h1000 ||
            tl_a_opcode !== 3'd6 || tl_a_param !== 3'd1 || last_grant !== 2'd2) begin
            n_err++; $display("FAIL single_out valid=%b src=%h addr=%h op=%0d prm=%0d lg=%0d want 1 25 1000 6 1 2",
                              tl_a_valid, tl_a_source, tl_a_address, tl_a_opcode, tl_a_param, last_grant);
        end
    endtask

    // Continues from test_single: the register is full and nobody is valid.
    task automatic test_idle_drain();
        step();
        n_vec++;
        if (tl_a_valid !== 1'b0) begin
            n_err++; $display("FAIL idle_drain_valid got %b want 0", tl_a_valid);
        end
        step();
        step();
        n_vec++;
        if (tl_a_valid !== 1'b0 || last_grant !== 2'd2) begin
            n_err++; $display("FAIL idle_hold valid=%b lg=%0d want 0 2", tl_a_valid, last_grant);
        end
    endtask

    // After a grant to core 2 (pointer at 3), cores 0 and 3 valid: 3 then 0.
    task automatic test_fair_pointer();
        set_core(0, 1'b1, 3'd4, 3'd2, 4'hA, 64'h2000);
        set_core(3, 1'b1, 3'd4, 3'd2, 4'hB, 64'h3000);
        #1;
        n_vec++;
        if (l1_a_ready !== 4'b1000) begin
            n_err++; $display("FAIL fair_ready1 got %b want 1000", l1_a_ready);
        end
        step();
        n_vec++;
        if (tl_a_source !== 6'h3B || tl_a_address !== 64'h3000) begin
            n_err++; $display("FAIL fair_grant1 src=%h addr=%h want 3b 3000", tl_a_source, tl_a_address);
        end
        n_vec++;
        if (l1_a_ready !== 4'b0001) begin
            n_err++; $display("FAIL fair_ready2 got %b want 0001", l1_a_ready);
        end
        step();
        n_vec++;
        if (tl_a_source !== 6'h0A || tl_a_address !== 64'h2000 || last_grant !== 2'd0) begin
            n_err++; $display("FAIL fair_grant2 src=%h addr=%h lg=%0d want 0a 2000 0",
                              tl_a_source, tl_a_address, last_grant);
        end
        clear_all();
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ready;
        logic [5:0] exp_src;
        logic [63:0] exp_addr;
        clear_all();
        tl_a_ready = 1'b1;
        do_reset();
        for (int k = 0; k < CORES; k++) begin
            set_core(k, 1'b1, 3'(k), 3'd0, 4'(k + 8), 64'(k) * 64'h100 + 64'h8000);
        end
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_ready = 4'b0001 << (i % 4);
            n_vec++;
            if (l1_a_ready !== exp_ready) begin
                n_err++; $display("FAIL rr_ready[%0d] got %b want %b", i, l1_a_ready, exp_ready);
            end
            step();
            exp_src  = {2'(i % 4), 4'((i % 4) + 8)};
            exp_addr = 64'(i % 4) * 64'h100 + 64'h8000;
            n_vec++;
            if (tl_a_valid !== 1'b1 || tl_a_source !== exp_src || tl_a_address !== exp_addr ||
                tl_a_opcode !== 3'(i % 4)) begin
                n_err++; $display("FAIL rr_out[%0d] valid=%b src=%h addr=%h op=%0d want 1 %h %h %0d",
                                  i, tl_a_valid, tl_a_source, tl_a_address, tl_a_opcode,
                                  exp_src, exp_addr, i % 4);
            end
        end
        clear_all();
        step();
    endtask

    task automatic test_backpressure();
        clear_all();
        tl_a_ready = 1'b1;
        do_reset();
        set_core(0, 1'b1, 3'd5, 3'd3, 4'h7, 64'hAAAA);
        step();
        clear_all();
        tl_a_ready = 1'b0;
        set_core(1, 1'b1, 3'd6, 3'd1, 4'h2, 64'h1111);
        set_core(3, 1'b1, 3'd6, 3'd1, 4'h3, 64'h3333);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++;
            if (l1_a_ready !== 4'b0000) begin
                n_err++; $display("FAIL bp_ready[%0d] got %b want 0000", i, l1_a_ready);
            end
            step();
            n_vec++;
            if (tl_a_valid !== 1'b1 || tl_a_source !== 6'h07 || tl_a_address !== 64'hAAAA ||
                tl_a_opcode !== 3'd5 || tl_a_param !== 3'd3) begin
                n_err++; $display("FAIL bp_hold[%0d] valid=%b src=%h addr=%h op=%0d prm=%0d want 1 07 aaaa 5 3",
                                  i, tl_a_valid, tl_a_source, tl_a_address, tl_a_opcode, tl_a_param);
            end
        end
        tl_a_ready = 1'b1;
        #1;
        n_vec++;
        if (l1_a_ready !== 4'b0010) begin
            n_err++; $display("FAIL bp_release_ready got %b want 0010", l1_a_ready);
        end
        step();
        set_core(1, 1'b0, 3'd0, 3'd0, 4'h0, 64'h0);
        #1;
        n_vec++;
        if (tl_a_valid !== 1'b1 || tl_a_source !== 6'h12 || tl_a_address !== 64'h1111) begin
            n_err++; $display("FAIL bp_no_bubble valid=%b src=%h addr=%h want 1 12 1111",
                              tl_a_valid, tl_a_source, tl_a_address);
        end
        n_vec++;
        if (l1_a_ready !== 4'b1000) begin
            n_err++; $display("FAIL bp_next_ready got %b want 1000", l1_a_ready);
        end
        step();
        clear_all();
        step();
    endtask

    task automatic test_reset_mid();
        clear_all();
        tl_a_ready = 1'b1;
        set_core(3, 1'b1, 3'd6, 3'd2, 4'hC, 64'hBEEF);
        step();
        clear_all();
        tl_a_ready = 1'b0;
        set_core(2, 1'b1, 3'd6, 3'd2, 4'hD, 64'hCAFE);
        step();
        n_vec++;
        if (tl_a_valid !== 1'b1 || tl_a_source !== 6'h3C) begin
            n_err++; $display("FAIL rmid_setup valid=%b src=%h want 1 3c", tl_a_valid, tl_a_source);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({tl_a_valid, tl_a_opcode, tl_a_param, tl_a_source, tl_a_address, last_grant} !== '0 ||
            l1_a_ready !== 4'b0000) begin
            n_err++; $display("FAIL rmid_async valid=%b src=%h addr=%h lg=%0d rdy=%b want all 0",
                              tl_a_valid, tl_a_source, tl_a_address, last_grant, l1_a_ready);
        end
        step();
        rst = 1'b0;
        tl_a_ready = 1'b1;
        set_core(1, 1'b1, 3'd4, 3'd0, 4'h9, 64'h5000);
        #1;
        n_vec++;
        if (l1_a_ready !== 4'b0010) begin
            n_err++; $display("FAIL rmid_first_ready got %b want 0010", l1_a_ready);
        end
        step();
        n_vec++;
        if (tl_a_valid !== 1'b1 || tl_a_source !== 6'h19 || tl_a_address !== 64'h5000) begin
            n_err++; $display("FAIL rmid_first_grant valid=%b src=%h addr=%h want 1 19 5000",
                              tl_a_valid, tl_a_source, tl_a_address);
        end
        clear_all();
        step();
    endtask

    initial begin
        clear_all();
        tl_a_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_idle_drain();
        test_fair_pointer();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
